// File: rtl/chip8_mem_pkg.sv
// Shared constants and types for the Chip-8 memory port arbiter.
//   REQ_LD / REQ_CPU / REQ_DBG : requester indices (loader, CPU core, debug host)
//   NREQ                       : number of requesters
//   PROT_LIMIT                 : lowest writable address (font/interpreter area below)
//   state_e                    : arbiter lock state
package chip8_mem_pkg;
  localparam int REQ_LD  = 0;
  localparam int REQ_CPU = 1;
  localparam int REQ_DBG = 2;
  localparam int NREQ    = 3;

  localparam logic [11:0] PROT_LIMIT = 12'h200;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;
endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection.
//   req      : per-requester request
//   last_dbg : 1 = DBG was served last among CPU/DBG, 0 = CPU was
//   locked   : bus is locked to owner
//   owner    : one-hot lock owner (valid when locked)
//   gnt      : one-hot (or zero) grant
module mem_arb_pick (
  input  logic [2:0] req,
  input  logic       last_dbg,
  input  logic       locked,
  input  logic [2:0] owner,
  output logic [2:0] gnt
);
  import chip8_mem_pkg::*;

  always_comb begin
    gnt = '0;
    if (locked) begin
      gnt = req & owner;
    end else if (req[REQ_LD]) begin
      gnt[REQ_LD] = 1'b1;
    end else if (req[REQ_CPU] && req[REQ_DBG]) begin
      // Tie between CPU and DBG: whoever was not served last wins.
      if (last_dbg) gnt[REQ_CPU] = 1'b1;
      else          gnt[REQ_DBG] = 1'b1;
    end else if (req[REQ_CPU]) begin
      gnt[REQ_CPU] = 1'b1;
    end else if (req[REQ_DBG]) begin
      gnt[REQ_DBG] = 1'b1;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Shares the Chip-8 memory port A between loader (0), CPU (1) and debug (2).
//   clk, reset              : clock, synchronous active-high reset
//   req/we/lock [2:0]       : per-requester request, write flag, bus lock
//   addr [3*ADDR_W]         : per-requester address, slice n = addr[n*ADDR_W +: ADDR_W]
//   wdata [3*DATA_W]        : per-requester write data
//   gnt [2:0]               : one-hot grant; access accepted when req[n] & gnt[n]
//   rvalid [2:0], rdata     : read response one cycle after an accepted read
//   wr_err [2:0]            : pulse one cycle after an accepted write below PROT_LIMIT
//   mem_en/mem_write/mem_addr/mem_wdata/mem_rdata : memory port
//   dbg_state               : current lock state
// Handshake: a requester raises req with we/addr/wdata/lock and holds
// req/we/addr/wdata stable until the cycle where gnt[n] is high; that cycle
// is the transfer. Read data follows exactly one cycle later with rvalid[n].
module mem_arbiter #(
  parameter int          ADDR_W     = 12,
  parameter int          DATA_W     = 8,
  parameter logic [ADDR_W-1:0] PROT_LIMIT = chip8_mem_pkg::PROT_LIMIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            req,
  input  logic [2:0]            we,
  input  logic [3*ADDR_W-1:0]   addr,
  input  logic [3*DATA_W-1:0]   wdata,
  input  logic [2:0]            lock,
  output logic [2:0]            gnt,
  output logic [2:0]            rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic [2:0]            wr_err,
  output logic                  mem_en,
  output logic                  mem_write,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output chip8_mem_pkg::state_e dbg_state
);
  import chip8_mem_pkg::*;

  state_e     state_q, state_d;
  logic [2:0] owner_q, owner_d;
  logic       last_dbg_q, last_dbg_d;
  logic [2:0] rd_owner_q, rd_owner_d;
  logic [2:0] wr_flag_q, wr_flag_d;
  logic [2:0] pick_gnt;

  mem_arb_pick u_pick (
    .req      (req),
    .last_dbg (last_dbg_q),
    .locked   (state_q == LOCKED),
    .owner    (owner_q),
    .gnt      (pick_gnt)
  );

  assign gnt    = reset ? 3'b000 : pick_gnt;
  assign mem_en = |gnt;

  // Memory port mux of the granted requester.
  always_comb begin
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int n = 0; n < NREQ; n++) begin
      if (gnt[n]) begin
        mem_write = we[n];
        mem_addr  = addr[n*ADDR_W +: ADDR_W];
        mem_wdata = wdata[n*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_dbg_d = last_dbg_q;
    if (gnt[REQ_CPU]) last_dbg_d = 1'b0;
    if (gnt[REQ_DBG]) last_dbg_d = 1'b1;
    case (state_q)
      IDLE: begin
        if ((gnt & lock) != 3'b000) begin
          state_d = LOCKED;
          owner_d = gnt;
        end
      end
      LOCKED: begin
        // The owner's last access is still granted this cycle; release at the edge.
        if ((owner_q & lock & req) == 3'b000) begin
          state_d = IDLE;
          owner_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    rd_owner_d = gnt & ~we;
    wr_flag_d  = '0;
    if (mem_write && (mem_addr < PROT_LIMIT)) wr_flag_d = gnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      last_dbg_q <= 1'b1;
      rd_owner_q <= '0;
      wr_flag_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_dbg_q <= last_dbg_d;
      rd_owner_q <= rd_owner_d;
      wr_flag_q  <= wr_flag_d;
    end
  end

  // A response still in flight when reset asserts is suppressed immediately.
  assign rvalid    = rd_owner_q & {3{~reset}};
  assign wr_err    = wr_flag_q & {3{~reset}};
  assign rdata     = mem_rdata;
  assign dbg_state = state_q;
endmodule
